branch_sequencer: RTL
=====================

# branch_sequencer

Sequences loop-bracket resolution for the BeeF core. On a taken conditional branch (`CBF` with zero cell, `CBB` with non-zero cell) it takes over program-counter stepping and scans instruction memory one fetch per step, tracking bracket nesting depth until it finds the matching bracket. During the scan it suppresses architectural side effects, then returns control to normal execution. It sits between the fetch stage/PC register and the per-instruction control decoders (including `branch_control`).

## Interface
Parameters:
- `DEPTH_W`, default 8: width of the nesting-depth counter; maximum depth is 2^DEPTH_W − 1.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  `instruction` holds a valid fetched opcode this cycle.
- `instruction`  in  `op_code`  current fetched opcode (`definitions::op_code`).
- `acc_zero`  in  1  current data cell is zero.
- `pc_at_start`  in  1  PC is at address 0.
- `pc_at_end`  in  1  PC is at the last program address.
- `pc_inc`  out  1  advance PC by +1 this cycle.
- `pc_dec`  out  1  step PC by −1 this cycle.
- `exec_enable`  out  1  current instruction may commit side effects; decoders gate writes with it.
- `scan_active`  out  1  FSM is in `SCAN_FWD` or `SCAN_BWD`.
- `depth`  out  `DEPTH_W`  current nesting depth.
- `branch_error`  out  1  sticky fault: unmatched bracket or depth overflow.

## Operation
- States (`branch_state_t`): `RUN`, `SCAN_FWD`, `SCAN_BWD`, `FAULT`.
- **RUN**, with `instr_valid`:
  - `CBF` and `acc_zero`: go to `SCAN_FWD`, set `depth`=1, assert `pc_inc`, set `exec_enable`=0.
  - `CBB` and not `acc_zero`: go to `SCAN_BWD`, set `depth`=1, assert `pc_dec`, set `exec_enable`=0.
  - Any other instruction (including an untaken `CBF`/`CBB`): assert `pc_inc` and `exec_enable`=1.
- **SCAN_FWD**, with `instr_valid`:
  - `CBF`: `depth`+1.
  - `CBB` with `depth`>1: `depth`−1.
  - `CBB` with `depth`==1: matching bracket found; set `depth`=0, go to `RUN`, assert `pc_inc`. The next fetch is the instruction after the `]`.
  - Every non-terminating step asserts `pc_inc`.
- **SCAN_BWD**: mirror of `SCAN_FWD`.
  - `CBB`: `depth`+1.
  - `CBF` with `depth`>1: `depth`−1.
  - `CBF` with `depth`==1: matching bracket found; go to `RUN`, assert `pc_inc`. The next fetch is the instruction after the `[`.
  - Every non-terminating step asserts `pc_dec`.
- In both scan states, all other opcodes leave `depth` unchanged, and `exec_enable`=0 on every cycle.
- **Fault conditions:**
  - `SCAN_FWD` with `pc_at_end` and no match this cycle → `FAULT`.
  - `SCAN_BWD` with `pc_at_start` and no match this cycle → `FAULT`.
  - Increment while `depth` == 2^DEPTH_W − 1 → `FAULT`. The depth counter never wraps.
- **FAULT** is absorbing until `reset`:
  - `branch_error`=1, `pc_inc`=`pc_dec`=0, `exec_enable`=0.
- `depth` is unsigned modulo-free. Decrement below 1 cannot occur, because a match exits first.

## Timing
- After `reset`: state `RUN`, `depth`=0, `branch_error`=0, `scan_active`=0.
- `pc_inc`, `pc_dec` and `exec_enable` are combinational from state, `instruction`, `acc_zero` and `instr_valid`. All three are 0 whenever `instr_valid`=0.
- State and `depth` update only on cycles with `instr_valid`=1. Idle cycles hold everything.
- `scan_active`, `depth` and `branch_error` are registered and reflect the state after the edge.
- `pc_inc` and `pc_dec` are never asserted together.
- Scan cost: a matching bracket k fetches away takes k+1 valid cycles, counting the initiating branch.
- `reset` asserted mid-scan returns to `RUN` on the next edge, with `depth`=0.
- A match and a bound condition in the same cycle resolve as a match (no fault).

## Structure
- Add to the `definitions` package:
  - `branch_state_t` enum (`RUN`, `SCAN_FWD`, `SCAN_BWD`, `FAULT`).
  - `BRANCH_DEPTH_W` = 8, used as the default for `DEPTH_W`.
- One sub-module, `bracket_depth_counter`:
  - Saturating up/down counter with load-to-1.
  - Outputs: `at_one`, `at_max`.
- The FSM and PC-step decode stay in `branch_sequencer`.

## Test plan
- Program `CBF, NOP, CBB, NOP` with `acc_zero`=1: cycle 0 enters `SCAN_FWD` with `depth` 1; the `CBB` fetch returns to `RUN` with `depth` 0; `exec_enable`=0 for 3 cycles, then 1.
- Nested `CBF CBF NOP CBB CBB` forward scan: `depth` goes 1, 2, 2, 1, then match on the final `CBB`. The inner `CBB` must not terminate the scan.
- `CBB` with `acc_zero`=0 over `CBF NOP CBB`: `pc_dec` is asserted for 2 cycles, then `pc_inc` on the `CBF` match and a return to `RUN`.
- Untaken `CBF` (`acc_zero`=0) and untaken `CBB` (`acc_zero`=1): both give `pc_inc`=1, `exec_enable`=1, and the state stays `RUN`.
- Unmatched `CBF` with `pc_at_end` asserted mid-scan: `branch_error`=1 next cycle and stays set; `pc_inc` and `pc_dec` stay 0 until `reset` clears everything.
- `DEPTH_W`=2 with four nested `CBF`: `FAULT` on the third increment attempt past `depth` 3. Separately, `reset` asserted during a scan gives `RUN` with `depth` 0 on the next edge.

Source files
------------

// File: rtl/definitions.sv
// Shared BeeF core types: opcode encoding and the branch sequencer state set.
package definitions;

  typedef enum logic [3:0] {
    NOP      = 4'd0,
    INC_PTR  = 4'd1,
    DEC_PTR  = 4'd2,
    INC_CELL = 4'd3,
    DEC_CELL = 4'd4,
    OUT      = 4'd5,
    IN       = 4'd6,
    CBF      = 4'd7,
    CBB      = 4'd8,
    HALT     = 4'd9
  } op_code;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SCAN_FWD = 2'd1,
    SCAN_BWD = 2'd2,
    FAULT    = 2'd3
  } branch_state_t;

  localparam int BRANCH_DEPTH_W = 8;

endpackage

// File: rtl/bracket_depth_counter.sv
// Bracket nesting depth: load-to-1, saturating up/down count, clear to 0.
module bracket_depth_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_one,
  input  logic         inc,
  input  logic         dec,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         at_one,
  output logic         at_max
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load_one) begin
      count <= ONE;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign at_one = (count == ONE);
  assign at_max = (count == MAX);

endmodule

// File: rtl/branch_sequencer.sv
// Loop-bracket resolver: takes over PC stepping on a taken CBF/CBB and scans
// for the matching bracket while suppressing side effects.
module branch_sequencer
  import definitions::*;
#(
  parameter int DEPTH_W = BRANCH_DEPTH_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  input  op_code             instruction,
  input  logic               acc_zero,
  input  logic               pc_at_start,
  input  logic               pc_at_end,
  output logic               pc_inc,
  output logic               pc_dec,
  output logic               exec_enable,
  output logic               scan_active,
  output logic [DEPTH_W-1:0] depth,
  output logic               branch_error,
  output branch_state_t      state
);

  // instr_valid is a one-way qualifier (no ready): a cycle with it low is an
  // idle cycle, all step/enable outputs are 0 and no state or depth changes.
  branch_state_t next_state;
  logic cnt_load, cnt_inc, cnt_dec, cnt_clear;
  logic at_one, at_max;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    pc_inc      = 1'b0;
    pc_dec      = 1'b0;
    exec_enable = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    cnt_dec     = 1'b0;
    cnt_clear   = 1'b0;
    if (instr_valid) begin
      case (state)
        RUN: begin
          if (instruction == CBF && acc_zero) begin
            next_state = SCAN_FWD;
            cnt_load   = 1'b1;
            pc_inc     = 1'b1;
          end else if (instruction == CBB && !acc_zero) begin
            next_state = SCAN_BWD;
            cnt_load   = 1'b1;
            pc_dec     = 1'b1;
          end else begin
            pc_inc      = 1'b1;
            exec_enable = 1'b1;
          end
        end
        SCAN_FWD: begin
          pc_inc = 1'b1;
          if (instruction == CBB && at_one) begin
            next_state = RUN;
            cnt_clear  = 1'b1;
          end else begin
            // A match wins over the end bound, so the bound is checked only here.
            if (pc_at_end) next_state = FAULT;
            if (instruction == CBF) begin
              if (at_max) next_state = FAULT;
              else        cnt_inc    = 1'b1;
            end else if (instruction == CBB) begin
              cnt_dec = 1'b1;
            end
          end
        end
        SCAN_BWD: begin
          if (instruction == CBF && at_one) begin
            next_state = RUN;
            cnt_clear  = 1'b1;
            pc_inc     = 1'b1;
          end else begin
            pc_dec = 1'b1;
            if (pc_at_start) next_state = FAULT;
            if (instruction == CBB) begin
              if (at_max) next_state = FAULT;
              else        cnt_inc    = 1'b1;
            end else if (instruction == CBF) begin
              cnt_dec = 1'b1;
            end
          end
        end
        default: begin
          next_state = FAULT;
        end
      endcase
    end
  end

  bracket_depth_counter #(.W(DEPTH_W)) u_depth (
    .clock    (clock),
    .reset    (reset),
    .load_one (cnt_load),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .count    (depth),
    .at_one   (at_one),
    .at_max   (at_max)
  );

  assign scan_active  = (state == SCAN_FWD) || (state == SCAN_BWD);
  assign branch_error = (state == FAULT);

endmodule
